// File: rtl/logic_unit_arbiter_pkg.sv
// Shared definitions for the logic unit arbiter.
//   state_e   : arbiter FSM encoding (IDLE = 0, EXEC = 1)
//   REQ0/REQ1 : requester identifiers, used for the winner and `last` pointer
package logic_unit_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StExec = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/logic_unit_core.sv
// Shared two-input logic unit, purely combinational.
//   i_a, i_b : operands
//   o_y1     : (a & b) ^ (a | b)
//   o_y2     : ~b
module logic_unit_core (
  input  logic i_a,
  input  logic i_b,
  output logic o_y1,
  output logic o_y2
);

  assign o_y1 = (i_a & i_b) ^ (i_a | i_b);
  assign o_y2 = ~i_b;

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_unit_core between two requesters.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_req0/1            : requests, sampled only in IDLE
//   i_a0/i_b0, i_a1/i_b1: operand pairs of each requester
//   o_gnt0/1            : one-cycle grant pulse (operands latched)
//   o_vld0/1            : one-cycle result-valid pulse
//   o_res1/o_res2       : registered results of the last transaction
//   o_cnt0/1            : completed transactions per requester (wrapping)
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic             i_req1,
  input  logic             i_a0,
  input  logic             i_b0,
  input  logic             i_a1,
  input  logic             i_b1,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_vld0,
  output logic             o_vld1,
  output logic             o_res1,
  output logic             o_res2,
  output logic [CNT_W-1:0] o_cnt0,
  output logic [CNT_W-1:0] o_cnt1
);

  state_e           r_state;
  state_e           w_state_d;
  logic             r_last;
  logic             r_win;
  logic             r_op_a;
  logic             r_op_b;
  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_vld0;
  logic             r_vld1;
  logic             r_res1;
  logic             r_res2;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_any_req;
  logic             w_win;
  logic             w_y1;
  logic             w_y2;

  assign w_any_req = i_req0 | i_req1;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    w_win = REQ0;
    if (i_req0 && i_req1) begin
      w_win = ~r_last;
    end else if (i_req1) begin
      w_win = REQ1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_d = StExec;
      StExec:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  logic_unit_core u_core (
    .i_a  (r_op_a),
    .i_b  (r_op_b),
    .o_y1 (w_y1),
    .o_y2 (w_y2)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= REQ1;
      r_win  <= REQ0;
      r_op_a <= 1'b0;
      r_op_b <= 1'b0;
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      r_res1 <= 1'b0;
      r_res2 <= 1'b0;
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      // Grant and valid are single-cycle pulses.
      r_gnt0 <= 1'b0;
      r_gnt1 <= 1'b0;
      r_vld0 <= 1'b0;
      r_vld1 <= 1'b0;
      if (r_state == StIdle && w_any_req) begin
        r_win  <= w_win;
        r_op_a <= (w_win == REQ1) ? i_a1 : i_a0;
        r_op_b <= (w_win == REQ1) ? i_b1 : i_b0;
        r_gnt0 <= (w_win == REQ0);
        r_gnt1 <= (w_win == REQ1);
      end else if (r_state == StExec) begin
        r_res1 <= w_y1;
        r_res2 <= w_y2;
        r_last <= r_win;
        if (r_win == REQ1) begin
          r_vld1 <= 1'b1;
          r_cnt1 <= r_cnt1 + CNT_W'(1);
        end else begin
          r_vld0 <= 1'b1;
          r_cnt0 <= r_cnt0 + CNT_W'(1);
        end
      end
    end
  end

  assign o_gnt0 = r_gnt0;
  assign o_gnt1 = r_gnt1;
  assign o_vld0 = r_vld0;
  assign o_vld1 = r_vld1;
  assign o_res1 = r_res1;
  assign o_res2 = r_res2;
  assign o_cnt0 = r_cnt0;
  assign o_cnt1 = r_cnt1;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter. Two instances (CNT_W = 8 and
// CNT_W = 2) share all inputs; the narrow one exercises counter wrap.
module tb_logic_unit_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;

  logic       gnt0, gnt1, vld0, vld1, res1, res2;
  logic [7:0] cnt0, cnt1;
  logic       n_gnt0, n_gnt1, n_vld0, n_vld1, n_res1, n_res2;
  logic [1:0] n_cnt0, n_cnt1;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.CNT_W(8)) dut (
    .i_clk (clk), .i_rst (rst),
    .i_req0 (req0), .i_req1 (req1),
    .i_a0 (a0), .i_b0 (b0), .i_a1 (a1), .i_b1 (b1),
    .o_gnt0 (gnt0), .o_gnt1 (gnt1), .o_vld0 (vld0), .o_vld1 (vld1),
    .o_res1 (res1), .o_res2 (res2), .o_cnt0 (cnt0), .o_cnt1 (cnt1)
  );

  logic_unit_arbiter #(.CNT_W(2)) dut_w2 (
    .i_clk (clk), .i_rst (rst),
    .i_req0 (req0), .i_req1 (req1),
    .i_a0 (a0), .i_b0 (b0), .i_a1 (a1), .i_b1 (b1),
    .o_gnt0 (n_gnt0), .o_gnt1 (n_gnt1), .o_vld0 (n_vld0), .o_vld1 (n_vld1),
    .o_res1 (n_res1), .o_res2 (n_res2), .o_cnt0 (n_cnt0), .o_cnt1 (n_cnt1)
  );

  typedef struct {
    logic       id;
    logic       r1;
    logic       r2;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  // Reference model state.
  logic       m_exec;
  logic       m_last;
  logic       m_pend;
  logic [7:0] m_cnt[2];
  logic       m_res1, m_res2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_exec = 1'b0;
    m_last = 1'b1;
    m_cnt[0] = 8'd0;
    m_cnt[1] = 8'd0;
    m_res1 = 1'b0;
    m_res2 = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {6'd0, gnt1, gnt0}, 8'd0);
    chk({tag, "_vld"}, {6'd0, vld1, vld0}, 8'd0);
    chk({tag, "_res"}, {6'd0, res1, res2}, 8'd0);
    chk({tag, "_cnt0"}, cnt0, 8'd0);
    chk({tag, "_cnt1"}, cnt1, 8'd0);
    chk({tag, "_w2cnt"}, {4'd0, n_cnt1, n_cnt0}, 8'd0);
  endtask

  // One clock cycle: drive inputs, predict, then check just after the edge.
  task automatic cycle(input logic r0, input logic ia0, input logic ib0,
                       input logic r1, input logic ia1, input logic ib1);
    logic eg0, eg1, ev, win, oa, ob;
    exp_t e;
    req0 = r0; a0 = ia0; b0 = ib0;
    req1 = r1; a1 = ia1; b1 = ib1;
    eg0 = 1'b0; eg1 = 1'b0; ev = 1'b0;
    if (m_exec) begin
      m_exec = 1'b0;
      ev = 1'b1;
    end else if (r0 || r1) begin
      win = (r0 && r1) ? ~m_last : (r0 ? 1'b0 : 1'b1);
      oa = win ? ia1 : ia0;
      ob = win ? ib1 : ib0;
      m_cnt[win] = m_cnt[win] + 8'd1;
      e.id = win;
      e.r1 = (oa & ob) ^ (oa | ob);
      e.r2 = ~ob;
      e.cnt = m_cnt[win];
      sb.push_back(e);
      m_last = win;
      m_exec = 1'b1;
      eg0 = ~win;
      eg1 = win;
    end
    @(posedge clk);
    #1;
    chk("gnt0", {7'd0, gnt0}, {7'd0, eg0});
    chk("gnt1", {7'd0, gnt1}, {7'd0, eg1});
    if (ev) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 8'd0, 8'd1);
      end else begin
        e = sb.pop_front();
        m_res1 = e.r1;
        m_res2 = e.r2;
        chk("vld0", {7'd0, vld0}, {7'd0, ~e.id});
        chk("vld1", {7'd0, vld1}, {7'd0, e.id});
        chk("cnt", e.id ? cnt1 : cnt0, e.cnt);
        chk("cnt_w2", {6'd0, e.id ? n_cnt1 : n_cnt0}, e.cnt & 8'd3);
      end
    end else begin
      chk("no_vld", {6'd0, vld1, vld0}, 8'd0);
    end
    chk("res1", {7'd0, res1}, {7'd0, m_res1});
    chk("res2", {7'd0, res2}, {7'd0, m_res2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Assert reset asynchronously between edges, release at the next negedge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    #1;
    chk_reset_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 0: a=1,b=1 -> (0,0).
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Single request from requester 1: a=1,b=0 -> (1,1).
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Both held for 8 cycles: grants alternate 0,1,0,1.
    do_reset("rr");
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(1);
    chk("rr_cnt0", cnt0, 8'd2);
    chk("rr_cnt1", cnt1, 8'd2);

    // Reset while gnt0 is high aborts the transaction.
    do_reset("pre_abort");
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset("abort");
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // req0 held 10 cycles: narrow counter goes 1,2,3,0,1.
    do_reset("wrap");
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk("wrap_cnt0_w2", {6'd0, n_cnt0}, 8'd1);
    chk("wrap_cnt0", cnt0, 8'd5);

    // req0 pulsed only during EXEC is dropped.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    chk("exec_req_cnt0", cnt0, 8'd5);
    chk("exec_req_cnt1", cnt1, 8'd1);

    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
